// File: rtl/vend_timeout_timer_pkg.sv
// Shared definitions for the vending timeout timer: FSM state encodings and defaults.
// The same encodings are used by the vending FSM that consumes the timer.
package vend_timeout_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT_S = 30;
    localparam int DEFAULT_CNT_W     = 6;

endpackage

// File: rtl/vend_bin2bcd.sv
// Registered binary-to-BCD converter (two digits) for values up to 99.
// Outputs lag the input by one clock.
module vend_bin2bcd #(
    parameter int W = 6
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_bin,
    output logic [3:0]   o_tens,
    output logic [3:0]   o_ones
);

    logic [W+3:0] w_bin_ext;
    logic [W+3:0] w_tens_full;
    logic [W+3:0] w_ones_full;
    logic [3:0]   r_tens;
    logic [3:0]   r_ones;

    // Widened so the constant 10 always fits, whatever W is.
    assign w_bin_ext   = {4'b0000, i_bin};
    assign w_tens_full = w_bin_ext / (W+4)'(10);
    assign w_ones_full = w_bin_ext % (W+4)'(10);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else begin
            r_tens <= w_tens_full[3:0];
            r_ones <= w_ones_full[3:0];
        end
    end

    assign o_tens = r_tens;
    assign o_ones = r_ones;

endmodule

// File: rtl/vend_timeout_timer.sv
// Seconds countdown for the vending coin/selection timeout, driven by the 1 Hz divider tick.
// Optional BCD display outputs are enabled by defining VEND_TIMER_BCD_EN.
module vend_timeout_timer
    import vend_timeout_timer_pkg::*;
#(
    parameter int TIMEOUT_S = DEFAULT_TIMEOUT_S,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clk1hz,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_clear,
    output logic             o_busy,
    output logic             o_expired,
    output logic [CNT_W-1:0] o_secs_left,
    output state_t           o_state
`ifdef VEND_TIMER_BCD_EN
    ,
    output logic [3:0]       o_bcd_tens,
    output logic [3:0]       o_bcd_ones
`endif
);

    if (TIMEOUT_S < 1 || TIMEOUT_S > (2**CNT_W) - 1) begin : g_bad_timeout
        $error("vend_timeout_timer: TIMEOUT_S out of range 1..2**CNT_W-1");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_secs_left;
    logic             r_busy;
    logic             r_expired;
    logic             r_clk1hz_q;
    logic             w_tick;

    // r_clk1hz_q resets high so a clk1hz already high at reset release is not a tick.
    assign w_tick = i_clk1hz & ~r_clk1hz_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_secs_left <= '0;
            r_busy      <= 1'b0;
            r_expired   <= 1'b0;
            r_clk1hz_q  <= 1'b1;
        end else begin
            r_clk1hz_q <= i_clk1hz;
            r_expired  <= 1'b0;
            if (i_clear) begin
                r_state     <= ST_IDLE;
                r_secs_left <= '0;
                r_busy      <= 1'b0;
            end else if (i_start) begin
                r_state     <= ST_RUN;
                r_secs_left <= CNT_W'(TIMEOUT_S);
                r_busy      <= 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (i_pause) begin
                            r_state <= ST_HOLD;
                        end else if (w_tick) begin
                            // Last second (or a zero count) finishes instead of wrapping.
                            if (r_secs_left > CNT_W'(1)) begin
                                r_secs_left <= r_secs_left - CNT_W'(1);
                            end else begin
                                r_secs_left <= '0;
                                r_expired   <= 1'b1;
                                r_busy      <= 1'b0;
                                r_state     <= ST_DONE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!i_pause) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_expired   = r_expired;
    assign o_secs_left = r_secs_left;
    assign o_state     = r_state;

`ifdef VEND_TIMER_BCD_EN
    vend_bin2bcd #(.W(CNT_W)) u_bin2bcd (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_bin   (r_secs_left),
        .o_tens  (o_bcd_tens),
        .o_ones  (o_bcd_ones)
    );
`endif

endmodule

// File: tb/tb_vend_timeout_timer.sv
// Directed bench for vend_timeout_timer (TIMEOUT_S=5); BCD scenario uses a second
// instance with TIMEOUT_S=42 when VEND_TIMER_BCD_EN is defined.
module tb_vend_timeout_timer;
    import vend_timeout_timer_pkg::*;

    localparam int CNT_W = 6;

    logic             clk;
    logic             i_reset;
    logic             i_clk1hz;
    logic             i_start;
    logic             i_pause;
    logic             i_clear;
    logic             o_busy;
    logic             o_expired;
    logic [CNT_W-1:0] o_secs_left;
    state_t           o_state;

    int checks;
    int errors;
    int pulses;

`ifdef VEND_TIMER_BCD_EN
    logic [3:0]       o_bcd_tens;
    logic [3:0]       o_bcd_ones;
    logic             i_start42;
    logic             o_busy42;
    logic             o_expired42;
    logic [CNT_W-1:0] o_secs42;
    state_t           o_state42;
    logic [3:0]       o_tens42;
    logic [3:0]       o_ones42;
`endif

    vend_timeout_timer #(.TIMEOUT_S(5), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_clk1hz    (i_clk1hz),
        .i_start     (i_start),
        .i_pause     (i_pause),
        .i_clear     (i_clear),
        .o_busy      (o_busy),
        .o_expired   (o_expired),
        .o_secs_left (o_secs_left),
        .o_state     (o_state)
`ifdef VEND_TIMER_BCD_EN
        ,
        .o_bcd_tens  (o_bcd_tens),
        .o_bcd_ones  (o_bcd_ones)
`endif
    );

`ifdef VEND_TIMER_BCD_EN
    vend_timeout_timer #(.TIMEOUT_S(42), .CNT_W(CNT_W)) dut42 (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_clk1hz    (i_clk1hz),
        .i_start     (i_start42),
        .i_pause     (1'b0),
        .i_clear     (1'b0),
        .o_busy      (o_busy42),
        .o_expired   (o_expired42),
        .o_secs_left (o_secs42),
        .o_state     (o_state42),
        .o_bcd_tens  (o_tens42),
        .o_bcd_ones  (o_ones42)
    );
`endif

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every expired pulse, counted shortly after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (o_expired === 1'b1) pulses++;
    end

    // Inputs are driven at negedge; one call advances through one posedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Finish the current clk1hz second after its rising edge: 500 high, 500 low.
    task automatic sec_rest();
        repeat (499) cyc();
        i_clk1hz = 1'b0;
        repeat (500) cyc();
    endtask

    task automatic test_reset();
        i_reset  = 1'b1;
        i_clk1hz = 1'b1;
        repeat (3) cyc();
        i_reset = 1'b0;
        cyc();
        checks++;
        if (o_secs_left !== 6'd0) begin errors++; $display("FAIL reset_secs got %0d want 0", o_secs_left); end
        checks++;
        if (o_busy !== 1'b0 || o_expired !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy=%b exp=%b want 0/0", o_busy, o_expired);
        end
        checks++;
        if (o_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", o_state); end
`ifdef VEND_TIMER_BCD_EN
        checks++;
        if (o_bcd_tens !== 4'd0 || o_bcd_ones !== 4'd0) begin
            errors++; $display("FAIL reset_bcd got %0d/%0d want 0/0", o_bcd_tens, o_bcd_ones);
        end
`endif
        repeat (100) cyc();
        i_clk1hz = 1'b0;
        repeat (500) cyc();
        checks++;
        if (pulses !== 0 || o_state !== ST_IDLE) begin
            errors++; $display("FAIL reset_quiet got pulses=%0d state=%0d want 0/0", pulses, o_state);
        end
    endtask

    task automatic test_countdown();
        int p0;
        p0 = pulses;
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        checks++;
        if (o_secs_left !== 6'd5 || o_busy !== 1'b1 || o_state !== ST_RUN) begin
            errors++; $display("FAIL cd_load got secs=%0d busy=%b state=%0d want 5/1/1", o_secs_left, o_busy, o_state);
        end
        for (int k = 1; k <= 5; k++) begin
            i_clk1hz = 1'b1;
            cyc();
            checks++;
            if (o_secs_left !== 6'(5 - k) || o_expired !== (k == 5) || o_busy !== (k < 5)) begin
                errors++;
                $display("FAIL cd_edge%0d got secs=%0d exp=%b busy=%b want %0d/%b/%b",
                         k, o_secs_left, o_expired, o_busy, 5 - k, k == 5, k < 5);
            end
            cyc();
            checks++;
            if (o_expired !== 1'b0 || o_secs_left !== 6'(5 - k)) begin
                errors++; $display("FAIL cd_after%0d got exp=%b secs=%0d want 0/%0d", k, o_expired, o_secs_left, 5 - k);
            end
            sec_rest();
        end
        checks++;
        if (o_state !== ST_DONE || o_busy !== 1'b0 || pulses - p0 !== 1) begin
            errors++; $display("FAIL cd_done got state=%0d busy=%b pulses=%0d want 3/0/1", o_state, o_busy, pulses - p0);
        end
    endtask

    task automatic test_pause();
        int p0;
        p0 = pulses;
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_clk1hz = 1'b1;
            cyc();
            sec_rest();
        end
        checks++;
        if (o_secs_left !== 6'd3) begin errors++; $display("FAIL pause_pre got %0d want 3", o_secs_left); end
        i_pause = 1'b1;
        cyc();
        checks++;
        if (o_state !== ST_HOLD || o_busy !== 1'b1) begin
            errors++; $display("FAIL pause_hold got state=%0d busy=%b want 2/1", o_state, o_busy);
        end
        for (int k = 0; k < 2; k++) begin
            i_clk1hz = 1'b1;
            cyc();
            checks++;
            if (o_secs_left !== 6'd3 || o_state !== ST_HOLD) begin
                errors++; $display("FAIL pause_edge%0d got secs=%0d state=%0d want 3/2", k, o_secs_left, o_state);
            end
            sec_rest();
        end
        // Release coincides with a rising edge: that tick must not count.
        i_pause  = 1'b0;
        i_clk1hz = 1'b1;
        cyc();
        checks++;
        if (o_secs_left !== 6'd3 || o_state !== ST_RUN) begin
            errors++; $display("FAIL pause_release got secs=%0d state=%0d want 3/1", o_secs_left, o_state);
        end
        sec_rest();
        for (int k = 1; k <= 3; k++) begin
            i_clk1hz = 1'b1;
            cyc();
            checks++;
            if (o_secs_left !== 6'(3 - k) || o_expired !== (k == 3)) begin
                errors++; $display("FAIL pause_post%0d got secs=%0d exp=%b want %0d/%b", k, o_secs_left, o_expired, 3 - k, k == 3);
            end
            sec_rest();
        end
        checks++;
        if (pulses - p0 !== 1 || o_state !== ST_DONE) begin
            errors++; $display("FAIL pause_done got pulses=%0d state=%0d want 1/3", pulses - p0, o_state);
        end
    endtask

    task automatic test_start_tick();
        i_start  = 1'b1;
        i_clk1hz = 1'b1;
        cyc();
        i_start = 1'b0;
        checks++;
        if (o_secs_left !== 6'd5 || o_state !== ST_RUN) begin
            errors++; $display("FAIL st_same got secs=%0d state=%0d want 5/1", o_secs_left, o_state);
        end
        sec_rest();
        for (int k = 0; k < 3; k++) begin
            i_clk1hz = 1'b1;
            cyc();
            sec_rest();
        end
        checks++;
        if (o_secs_left !== 6'd2) begin errors++; $display("FAIL st_mid got %0d want 2", o_secs_left); end
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        checks++;
        if (o_secs_left !== 6'd5 || o_busy !== 1'b1) begin
            errors++; $display("FAIL st_restart got secs=%0d busy=%b want 5/1", o_secs_left, o_busy);
        end
    endtask

    task automatic test_clear();
        int p0;
        p0 = pulses;
        for (int k = 0; k < 4; k++) begin
            i_clk1hz = 1'b1;
            cyc();
            if (k < 3) sec_rest();
        end
        checks++;
        if (o_secs_left !== 6'd1) begin errors++; $display("FAIL clr_pre got %0d want 1", o_secs_left); end
        repeat (499) cyc();
        i_clk1hz = 1'b0;
        repeat (499) cyc();
        i_clear = 1'b1;
        cyc();
        i_clear = 1'b0;
        checks++;
        if (o_state !== ST_IDLE || o_secs_left !== 6'd0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL clr_idle got state=%0d secs=%0d busy=%b want 0/0/0", o_state, o_secs_left, o_busy);
        end
        i_clk1hz = 1'b1;
        cyc();
        checks++;
        if (o_state !== ST_IDLE || o_secs_left !== 6'd0 || o_expired !== 1'b0) begin
            errors++; $display("FAIL clr_tick got state=%0d secs=%0d exp=%b want 0/0/0", o_state, o_secs_left, o_expired);
        end
        sec_rest();
        // clear outranks a simultaneous start.
        i_start = 1'b1;
        i_clear = 1'b1;
        cyc();
        i_start = 1'b0;
        i_clear = 1'b0;
        checks++;
        if (o_state !== ST_IDLE || o_secs_left !== 6'd0 || pulses - p0 !== 0) begin
            errors++; $display("FAIL clr_prio got state=%0d secs=%0d pulses=%0d want 0/0/0", o_state, o_secs_left, pulses - p0);
        end
    endtask

`ifdef VEND_TIMER_BCD_EN
    task automatic test_bcd();
        i_start42 = 1'b1;
        cyc();
        i_start42 = 1'b0;
        checks++;
        if (o_secs42 !== 6'd42 || o_tens42 !== 4'd0 || o_ones42 !== 4'd0) begin
            errors++; $display("FAIL bcd_lag got secs=%0d bcd=%0d/%0d want 42/0/0", o_secs42, o_tens42, o_ones42);
        end
        cyc();
        checks++;
        if (o_tens42 !== 4'd4 || o_ones42 !== 4'd2) begin
            errors++; $display("FAIL bcd_42 got %0d/%0d want 4/2", o_tens42, o_ones42);
        end
        i_clk1hz = 1'b1;
        cyc();
        cyc();
        checks++;
        if (o_secs42 !== 6'd41 || o_tens42 !== 4'd4 || o_ones42 !== 4'd1) begin
            errors++; $display("FAIL bcd_41 got secs=%0d bcd=%0d/%0d want 41/4/1", o_secs42, o_tens42, o_ones42);
        end
        sec_rest();
    endtask
`endif

    initial begin
        checks   = 0;
        errors   = 0;
        pulses   = 0;
        i_reset  = 1'b1;
        i_clk1hz = 1'b1;
        i_start  = 1'b0;
        i_pause  = 1'b0;
        i_clear  = 1'b0;
`ifdef VEND_TIMER_BCD_EN
        i_start42 = 1'b0;
`endif
        test_reset();
        test_countdown();
        test_pause();
        test_start_tick();
        test_clear();
`ifdef VEND_TIMER_BCD_EN
        test_bcd();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
